// File: rtl/qsys_tabby_pkg.sv
// Shared constants for the Tabby event controller: register map, read FSM encoding, ID.
// Latency: n/a (constants only).
// Backpressure: n/a.
package qsys_tabby_pkg;

    // Word addresses of the register map
    localparam logic [4:0] REG_RAW      = 5'd0;
    localparam logic [4:0] REG_PEND     = 5'd1;
    localparam logic [4:0] REG_MASK     = 5'd2;
    localparam logic [4:0] REG_EDGE     = 5'd3;
    localparam logic [4:0] REG_POL      = 5'd4;
    localparam logic [4:0] REG_FORCE    = 5'd5;
    localparam logic [4:0] REG_STATUS   = 5'd6;
    localparam logic [4:0] REG_ID       = 5'd7;
    localparam logic [4:0] REG_CNT_BASE = 5'd8;

    // Read handshake states
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_RD1  = 2'd1;
    localparam logic [1:0] RD_RD2  = 2'd2;

    localparam logic [31:0] DEF_ID_VALUE = 32'h5445_5643;

    // Expand the 4 byte enables into a 32-bit per-bit lane mask
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/qsys_tabby_evt_sync.sv
// One event line: input synchronizer, previous-value flop, edge/level detect.
// Latency: SYNC_STAGES cycles pin to lvl; evt_set/evt_rise are combinational from the flops.
// Backpressure: none, free-running every cycle.
module qsys_tabby_evt_sync
    import qsys_tabby_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic evt_in,
    input  logic pol,
    input  logic edge_mode,
    output logic lvl,
    output logic evt_set,
    output logic evt_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   act, act_prev;

    // Shift the raw pin through the synchronizer; remember last synchronized level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], evt_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and previous-value state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Polarity folds the falling-edge / active-low case into the same detector
    always_comb begin
        lvl      = sync_q[SYNC_STAGES-1];
        act      = lvl ^ pol;
        act_prev = prev_q ^ pol;
        evt_rise = act & ~act_prev;
        evt_set  = edge_mode ? evt_rise : act;
    end

endmodule

// File: rtl/qsys_tabby_evtctl.sv
// Avalon-MM event/interrupt controller: sync, detect, pend, mask, irq. Optional per-line event counters under QSYS_TABBY_EVTCTL_CNT_EN.
// Latency: pin to irq SYNC_STAGES+2 cycles; writes 1 cycle; reads readdatavalid 2 cycles after acceptance.
// Backpressure: waitrequest high for the 2 cycles after an accepted read; one outstanding read at a time.
module qsys_tabby_evtctl
    import qsys_tabby_pkg::*;
#(
    parameter int          NUM_EVT     = 10,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = DEF_ID_VALUE
) (
    input  logic               csi_MCLK_clk,
    input  logic               rsi_MRST_reset_n,
    input  logic [4:0]         avs_S1_address,
    input  logic               avs_S1_read,
    input  logic               avs_S1_write,
    input  logic [31:0]        avs_S1_writedata,
    input  logic [3:0]         avs_S1_byteenable,
    output logic [31:0]        avs_S1_readdata,
    output logic               avs_S1_readdatavalid,
    output logic               avs_S1_waitrequest,
    input  logic [NUM_EVT-1:0] coe_EVT_in,
    output logic [NUM_EVT-1:0] ins_IRQ_irq
);

    logic [NUM_EVT-1:0] pend_q, pend_d, mask_q, mask_d, edge_q, edge_d, pol_q, pol_d;
    logic [NUM_EVT-1:0] irq_q, irq_d;
    logic [NUM_EVT-1:0] lvl_sync, evt_set, evt_rise;
    logic [NUM_EVT-1:0] wmask, wbits, w1c, frc;
    logic [31:0]        be_lanes, rd_mux;
    logic [31:0]        snap_q, snap_d, rdata_q, rdata_d;
    logic [1:0]         rd_st_q, rd_st_d;
    logic               wr_acc;
    logic               unused_bits;

    for (genvar gi = 0; gi < NUM_EVT; gi++) begin : g_line
        qsys_tabby_evt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk       (csi_MCLK_clk),
            .rst_n     (rsi_MRST_reset_n),
            .evt_in    (coe_EVT_in[gi]),
            .pol       (pol_q[gi]),
            .edge_mode (edge_q[gi]),
            .lvl       (lvl_sync[gi]),
            .evt_set   (evt_set[gi]),
            .evt_rise  (evt_rise[gi])
        );
    end

    // Writes stall while a read is in flight; bits above NUM_EVT are simply dropped
    always_comb begin
        avs_S1_waitrequest = (rd_st_q != RD_IDLE);
        wr_acc   = avs_S1_write & ~avs_S1_waitrequest;
        be_lanes = be_to_mask(avs_S1_byteenable);
        wmask    = be_lanes[NUM_EVT-1:0];
        wbits    = avs_S1_writedata[NUM_EVT-1:0] & wmask;
    end

    // Register writes and pending update; a detected event always beats a same-cycle W1C
    always_comb begin
        mask_d = mask_q;
        edge_d = edge_q;
        pol_d  = pol_q;
        w1c    = '0;
        frc    = '0;
        if (wr_acc) begin
            case (avs_S1_address)
                REG_PEND:  w1c    = wbits;
                REG_MASK:  mask_d = (mask_q & ~wmask) | wbits;
                REG_EDGE:  edge_d = (edge_q & ~wmask) | wbits;
                REG_POL:   pol_d  = (pol_q  & ~wmask) | wbits;
                REG_FORCE: frc    = wbits;
                default: ;
            endcase
        end
        pend_d = (pend_q & ~w1c) | evt_set | frc;
        irq_d  = pend_q & mask_q;
    end

    // Control/status register state and registered interrupt vector
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= '0;
            pol_q  <= '0;
            irq_q  <= '0;
        end else begin
            pend_q <= pend_d;
            mask_q <= mask_d;
            edge_q <= edge_d;
            pol_q  <= pol_d;
            irq_q  <= irq_d;
        end
    end

`ifdef QSYS_TABBY_EVTCTL_CNT_EN
    logic [7:0] cnt_q [NUM_EVT];
    logic [7:0] cnt_d [NUM_EVT];

    // Saturating per-line event counters; a clear in the same cycle as an event wins
    always_comb begin
        for (int i = 0; i < NUM_EVT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_acc && avs_S1_byteenable[0] &&
                ({27'd0, avs_S1_address} == 32'(REG_CNT_BASE) + 32'(i))) begin
                cnt_d[i] = 8'd0;
            end else if (evt_rise[i] && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Counter state
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            for (int i = 0; i < NUM_EVT; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_EVT; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

    // Read mux over the live register state (sampled into the snapshot on acceptance)
    always_comb begin
        rd_mux = '0;
        case (avs_S1_address)
            REG_RAW:    rd_mux = 32'(lvl_sync);
            REG_PEND:   rd_mux = 32'(pend_q);
            REG_MASK:   rd_mux = 32'(mask_q);
            REG_EDGE:   rd_mux = 32'(edge_q);
            REG_POL:    rd_mux = 32'(pol_q);
            REG_STATUS: rd_mux = 32'(pend_q & mask_q);
            REG_ID:     rd_mux = ID_VALUE;
            default:    rd_mux = '0;
        endcase
`ifdef QSYS_TABBY_EVTCTL_CNT_EN
        for (int i = 0; i < NUM_EVT; i++) begin
            if ({27'd0, avs_S1_address} == 32'(REG_CNT_BASE) + 32'(i)) rd_mux = {24'd0, cnt_q[i]};
        end
`endif
    end

    // Read FSM: snapshot at acceptance so a same-cycle write is not visible, then two wait cycles
    always_comb begin
        rd_st_d = rd_st_q;
        snap_d  = snap_q;
        rdata_d = rdata_q;
        case (rd_st_q)
            RD_IDLE: begin
                if (avs_S1_read) begin
                    rd_st_d = RD_RD1;
                    snap_d  = rd_mux;
                end
            end
            RD_RD1: begin
                rd_st_d = RD_RD2;
                rdata_d = snap_q;
            end
            RD_RD2:  rd_st_d = RD_IDLE;
            default: rd_st_d = RD_IDLE;
        endcase
    end

    // Read FSM state; reset drops any read in flight
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            rd_st_q <= RD_IDLE;
            snap_q  <= '0;
            rdata_q <= '0;
        end else begin
            rd_st_q <= rd_st_d;
            snap_q  <= snap_d;
            rdata_q <= rdata_d;
        end
    end

    // Output drive
    always_comb begin
        avs_S1_readdata      = rdata_q;
        avs_S1_readdatavalid = (rd_st_q == RD_RD2);
        ins_IRQ_irq          = irq_q;
    end

`ifdef QSYS_TABBY_EVTCTL_CNT_EN
    assign unused_bits = ^{be_lanes, avs_S1_writedata};
`else
    assign unused_bits = ^{be_lanes, avs_S1_writedata, evt_rise};
`endif

endmodule

// File: tb/tb_qsys_tabby_evtctl.sv
module tb_qsys_tabby_evtctl;

    localparam int NE = 10;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    avs_S1_address = '0;
    logic          avs_S1_read = 1'b0;
    logic          avs_S1_write = 1'b0;
    logic [31:0]   avs_S1_writedata = '0;
    logic [3:0]    avs_S1_byteenable = '0;
    logic [31:0]   avs_S1_readdata;
    logic          avs_S1_readdatavalid;
    logic          avs_S1_waitrequest;
    logic [NE-1:0] coe_EVT_in = '0;
    logic [NE-1:0] ins_IRQ_irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qsys_tabby_evtctl #(.NUM_EVT(NE), .SYNC_STAGES(SS), .ID_VALUE(32'h5445_5643)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset_n     (rst_n),
        .avs_S1_address       (avs_S1_address),
        .avs_S1_read          (avs_S1_read),
        .avs_S1_write         (avs_S1_write),
        .avs_S1_writedata     (avs_S1_writedata),
        .avs_S1_byteenable    (avs_S1_byteenable),
        .avs_S1_readdata      (avs_S1_readdata),
        .avs_S1_readdatavalid (avs_S1_readdatavalid),
        .avs_S1_waitrequest   (avs_S1_waitrequest),
        .coe_EVT_in           (coe_EVT_in),
        .ins_IRQ_irq          (ins_IRQ_irq)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // hist[0] is the pin value sampled at the latest edge; s is hist[SS-1], previous s is hist[SS]
    logic [NE-1:0] hist [0:SS];
    logic [NE-1:0] m_pend = '0, m_mask = '0, m_edge = '0, m_pol = '0, m_irq = '0;
    logic [31:0]   m_rdata = '0;
    int            m_busy = 0;
    int            m_cnt [NE];
    logic [NE-1:0] ms, mp, ma, map, mrise, mset, mw1c, mfrc, mwm, mwd;
    logic          mwacc, mracc;
    int            ai;

    function automatic logic [31:0] model_rd(input logic [4:0] ad, input logic [NE-1:0] s);
        int idx;
        idx = int'(ad) - 8;
        case (ad)
            5'd0: return 32'(s);
            5'd1: return 32'(m_pend);
            5'd2: return 32'(m_mask);
            5'd3: return 32'(m_edge);
            5'd4: return 32'(m_pol);
            5'd6: return 32'(m_pend & m_mask);
            5'd7: return 32'h5445_5643;
            default: begin
`ifdef QSYS_TABBY_EVTCTL_CNT_EN
                if (idx >= 0 && idx < NE) return 32'(m_cnt[idx]);
`endif
                return 32'd0;
            end
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= SS; i++) hist[i] = '0;
            m_pend = '0; m_mask = '0; m_edge = '0; m_pol = '0; m_irq = '0;
            m_rdata = '0; m_busy = 0;
            for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        end else begin
            ms    = hist[SS-1];
            mp    = hist[SS];
            ma    = ms ^ m_pol;
            map   = mp ^ m_pol;
            mrise = ma & ~map;
            mset  = (m_edge & mrise) | (~m_edge & ma);
            mwacc = avs_S1_write && (m_busy == 0);
            mracc = avs_S1_read && (m_busy == 0);
            for (int i = 0; i < NE; i++) mwm[i] = avs_S1_byteenable[i / 8];
            mwd   = avs_S1_writedata[NE-1:0] & mwm;
            mw1c  = '0;
            mfrc  = '0;
            if (mracc) m_rdata = model_rd(avs_S1_address, ms);
            m_irq = m_pend & m_mask;
            ai = int'(avs_S1_address) - 8;
            for (int i = 0; i < NE; i++) begin
                if (mwacc && avs_S1_byteenable[0] && ai == i) m_cnt[i] = 0;
                else if (mrise[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
            end
            if (mwacc) begin
                case (avs_S1_address)
                    5'd1: mw1c = mwd;
                    5'd2: m_mask = (m_mask & ~mwm) | mwd;
                    5'd3: m_edge = (m_edge & ~mwm) | mwd;
                    5'd4: m_pol  = (m_pol  & ~mwm) | mwd;
                    5'd5: mfrc = mwd;
                    default: ;
                endcase
            end
            m_pend = (m_pend & ~mw1c) | mset | mfrc;
            if (mracc) m_busy = 2;
            else if (m_busy > 0) m_busy = m_busy - 1;
            for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = coe_EVT_in;
        end
    end

    // Per-cycle comparison of every registered output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("irq", 32'(ins_IRQ_irq), 32'(m_irq));
            chk("waitrequest", 32'(avs_S1_waitrequest), 32'(m_busy != 0));
            chk("readdatavalid", 32'(avs_S1_readdatavalid), 32'(m_busy == 1));
            if (m_busy == 1) chk("readdata", avs_S1_readdata, m_rdata);
        end
    end

    // ---------------- bus tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (avs_S1_waitrequest && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (avs_S1_waitrequest) chk("bus_idle_timeout", 32'(avs_S1_waitrequest), 32'd0);
    endtask

    task automatic wr(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wait_idle();
        avs_S1_address    = ad;
        avs_S1_writedata  = d;
        avs_S1_byteenable = be;
        avs_S1_write      = 1'b1;
        @(negedge clk);
        avs_S1_write      = 1'b0;
        avs_S1_byteenable = '0;
    endtask

    task automatic rd(input logic [4:0] ad, output logic [31:0] d, output int lat);
        int n;
        @(negedge clk);
        wait_idle();
        avs_S1_address = ad;
        avs_S1_read    = 1'b1;
        @(negedge clk);
        avs_S1_read = 1'b0;
        n = 1;
        while (!avs_S1_readdatavalid && n < 6) begin
            @(negedge clk);
            n++;
        end
        if (!avs_S1_readdatavalid) chk("read_timeout", 32'(avs_S1_readdatavalid), 32'd1);
        lat = n;
        d   = avs_S1_readdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    logic [31:0] rv;
    int          lat, c;
    logic        seen;
    logic [31:0] rnd;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_irq", 32'(ins_IRQ_irq), 32'd0);
        chk("rst_waitrequest", 32'(avs_S1_waitrequest), 32'd0);
        chk("rst_readdatavalid", 32'(avs_S1_readdatavalid), 32'd0);
        chk("rst_readdata", avs_S1_readdata, 32'd0);
        rst_n = 1'b1;

        rd(5'd7, rv, lat);
        chk("id_value", rv, 32'h5445_5643);
        chk("id_latency", 32'(lat), 32'd2);
        rd(5'd1, rv, lat);
        chk("pend_after_reset", rv, 32'd0);

        // Edge mode, line 0
        wr(5'd2, 32'h001, 4'hF);
        wr(5'd3, 32'h001, 4'hF);
        wr(5'd4, 32'h000, 4'hF);
        @(negedge clk); coe_EVT_in[0] = 1'b1;
        @(negedge clk); coe_EVT_in[0] = 1'b0;
        c = 1;
        while (!ins_IRQ_irq[0] && c < 10) begin @(negedge clk); c++; end
        chk("edge_latency", 32'(c), 32'd4);
        repeat (3) @(negedge clk);
        chk("edge_irq_held", 32'(ins_IRQ_irq), 32'h001);
        rd(5'd1, rv, lat);
        chk("edge_pend", rv, 32'h001);
        wr(5'd1, 32'h001, 4'hF);
        @(negedge clk);
        chk("edge_w1c_irq", 32'(ins_IRQ_irq), 32'h000);

        // Level mode, line 1
        wr(5'd3, 32'h000, 4'hF);
        wr(5'd2, 32'h002, 4'hF);
        coe_EVT_in[1] = 1'b1;
        repeat (6) @(negedge clk);
        wr(5'd1, 32'h002, 4'hF);
        repeat (2) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("level_pend_sticky", rv, 32'h002);
        chk("level_irq_sticky", 32'(ins_IRQ_irq), 32'h002);
        coe_EVT_in[1] = 1'b0;
        repeat (5) @(negedge clk);
        wr(5'd1, 32'h002, 4'hF);
        repeat (3) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("level_pend_cleared", rv, 32'h000);
        chk("level_irq_cleared", 32'(ins_IRQ_irq), 32'h000);

        // Inverted polarity edge on line 2
        wr(5'd3, 32'h004, 4'hF);
        wr(5'd2, 32'h004, 4'hF);
        wr(5'd4, 32'h004, 4'hF);
        coe_EVT_in[2] = 1'b1;
        repeat (6) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("pol_rise_ignored", rv, 32'h000);
        coe_EVT_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("pol_fall_sets", rv, 32'h004);
        chk("pol_irq", 32'(ins_IRQ_irq), 32'h004);
        wr(5'd1, 32'h004, 4'hF);
        wr(5'd4, 32'h000, 4'hF);

        // Software force
        wr(5'd2, 32'h0F0, 4'hF);
        wr(5'd5, 32'h3FF, 4'hF);
        repeat (2) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("force_pend", rv, 32'h3FF);
        rd(5'd6, rv, lat);
        chk("force_status", rv, 32'h0F0);
        chk("force_irq", 32'(ins_IRQ_irq), 32'h0F0);
        rd(5'd5, rv, lat);
        chk("force_reads_zero", rv, 32'h000);
        wr(5'd1, 32'h3FF, 4'hF);

        // Same-cycle W1C and edge set on line 3 (pending already set by force)
        wr(5'd3, 32'h008, 4'hF);
        wr(5'd5, 32'h008, 4'hF);
        @(negedge clk); coe_EVT_in[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        avs_S1_address = 5'd1; avs_S1_writedata = 32'h008; avs_S1_byteenable = 4'hF; avs_S1_write = 1'b1;
        @(negedge clk);
        avs_S1_write = 1'b0;
        repeat (2) @(negedge clk);
        rd(5'd1, rv, lat);
        chk("collide_set_wins", rv, 32'h008);
        coe_EVT_in[3] = 1'b0;
        wr(5'd1, 32'h3FF, 4'hF);

        // Byte lanes and bits above NUM_EVT
        wr(5'd2, 32'h0000_03FF, 4'b0010);
        rd(5'd2, rv, lat);
        chk("mask_lane1_only", rv, 32'h3F0);
        wr(5'd2, 32'hFFFF_FFFF, 4'hF);
        rd(5'd2, rv, lat);
        chk("mask_upper_bits_zero", rv, 32'h3FF);

        // Simultaneous read and write returns pre-write data
        @(negedge clk);
        wait_idle();
        avs_S1_address = 5'd2; avs_S1_writedata = 32'h00F; avs_S1_byteenable = 4'hF;
        avs_S1_read = 1'b1; avs_S1_write = 1'b1;
        @(negedge clk);
        avs_S1_read = 1'b0; avs_S1_write = 1'b0;
        @(negedge clk);
        chk("rdwr_data", avs_S1_readdata, 32'h3FF);
        rd(5'd2, rv, lat);
        chk("rdwr_post", rv, 32'h00F);

        // RAW shows synchronized levels
        coe_EVT_in = 10'h205;
        repeat (4) @(negedge clk);
        rd(5'd0, rv, lat);
        chk("raw_levels", rv, 32'h205);
        coe_EVT_in = '0;

        // Reset while a read is in RD1
        @(negedge clk);
        wait_idle();
        avs_S1_address = 5'd7; avs_S1_read = 1'b1;
        @(negedge clk);
        avs_S1_read = 1'b0;
        chk("rd1_waitrequest", 32'(avs_S1_waitrequest), 32'd1);
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (avs_S1_readdatavalid) seen = 1'b1; end
        chk("rst_drops_read", 32'(seen), 32'd0);
        chk("rst_waitrequest_low", 32'(avs_S1_waitrequest), 32'd0);
        rd(5'd2, rv, lat);
        chk("rst_mask_zero", rv, 32'd0);

        // Event counter on line 0: 300 rising edges
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            coe_EVT_in[0] = ~coe_EVT_in[0];
        end
        @(negedge clk); coe_EVT_in[0] = 1'b0;
        repeat (5) @(negedge clk);
        rd(5'd8, rv, lat);
`ifdef QSYS_TABBY_EVTCTL_CNT_EN
        chk("cnt_saturates", rv, 32'd255);
`else
        chk("cnt_absent", rv, 32'd0);
`endif
        wr(5'd8, 32'h0, 4'b0001);
        rd(5'd8, rv, lat);
        chk("cnt_cleared", rv, 32'd0);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                rnd = $urandom;
                coe_EVT_in = rnd[NE-1:0];
            end
            avs_S1_read  = 1'b0;
            avs_S1_write = 1'b0;
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    avs_S1_read    = 1'b1;
                    avs_S1_address = 5'($urandom_range(0, 20));
                end
                3, 4, 5: begin
                    avs_S1_write      = 1'b1;
                    avs_S1_address    = 5'($urandom_range(1, 9));
                    avs_S1_writedata  = $urandom;
                    avs_S1_byteenable = 4'($urandom);
                end
                6: begin
                    avs_S1_read       = 1'b1;
                    avs_S1_write      = 1'b1;
                    avs_S1_address    = 5'($urandom_range(0, 9));
                    avs_S1_writedata  = $urandom;
                    avs_S1_byteenable = 4'($urandom);
                end
                default: ;
            endcase
        end
        @(negedge clk);
        avs_S1_read  = 1'b0;
        avs_S1_write = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
